dmem_store_buffer: RTL and testbench

- Sits directly downstream of the processor's MEM-stage data port (MemAddr/MemWrite/MemRead/WriteData/MemData) and in front of the data RAM.
- Stores are posted into a small circular FIFO and drained to RAM through a req/ack write handshake, so the pipeline never waits on slow RAM writes.
- Loads are answered combinationally in the same cycle: from the youngest matching buffered store, otherwise from the RAM read port.

---
 rtl/dmem_store_buffer.sv | 152 +++++++++++++++
 tb/tb_dmem_store_buffer.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_store_buffer.sv
// Posted-store buffer between the MEM-stage data port and the data RAM, with same-cycle load forwarding.
// Optional store coalescing into the youngest entry is enabled by defining DMEM_COALESCE_EN.
module dmem_store_buffer #(
  parameter int DEPTH = 4,
  parameter int AW    = 16,
  parameter int DW    = 32
) (
  input  logic          Clock,
  input  logic          nReset,
  input  logic [AW-1:0] MemAddr,
  input  logic          MemWrite,
  input  logic          MemRead,
  input  logic [DW-1:0] WriteData,
  output logic [DW-1:0] MemData,
  output logic          RamWReq,
  output logic [AW-1:0] RamWAddr,
  output logic [DW-1:0] RamWData,
  input  logic          RamWAck,
  output logic [AW-1:0] RamRAddr,
  input  logic [DW-1:0] RamRData,
  output logic          Full,
  output logic          Empty,
  output logic          Overflow
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [CW-1:0] ONE_C   = CW'(1);

  logic [AW-1:0] addr_mem_r [DEPTH];
  logic [DW-1:0] data_mem_r [DEPTH];

  logic [PW-1:0] head_r;
  logic [PW-1:0] tail_r;
  logic [CW-1:0] count_r;
  logic          empty_r;
  logic          full_r;
  logic          overflow_r;

  logic [PW-1:0] head_next_s;
  logic [PW-1:0] tail_next_s;
  logic [CW-1:0] count_next_s;
  logic          pop_s;
  logic          push_s;
  logic          coalesce_s;
  logic          overflow_set_s;
  logic          fwd_hit_s;
  logic [DW-1:0] fwd_data_s;

  // Empty is a register, so reset drops the write request without waiting for a clock edge.
  assign RamWReq  = ~empty_r;
  assign RamWAddr = addr_mem_r[head_r];
  assign RamWData = data_mem_r[head_r];
  assign RamRAddr = MemAddr;
  assign Full     = full_r;
  assign Empty    = empty_r;
  assign Overflow = overflow_r;

  assign pop_s = RamWReq & RamWAck;

`ifdef DMEM_COALESCE_EN
  logic [PW-1:0] tail_last_s;

  assign tail_last_s = tail_r - PW'(1);

  // Merge into the youngest entry, unless it is the lone entry leaving this cycle.
  always_comb begin
    coalesce_s = 1'b0;
    if (MemWrite && !empty_r && (addr_mem_r[tail_last_s] == MemAddr) &&
        !((count_r == ONE_C) && pop_s)) begin
      coalesce_s = 1'b1;
    end else begin
      coalesce_s = 1'b0;
    end
  end
`else
  assign coalesce_s = 1'b0;
`endif

  assign push_s         = MemWrite & ~coalesce_s & (~full_r | pop_s);
  assign overflow_set_s = MemWrite & ~coalesce_s & full_r & ~pop_s;

  // Next pointer and occupancy values.
  always_comb begin
    head_next_s  = head_r;
    tail_next_s  = tail_r;
    count_next_s = count_r;
    if (pop_s) begin
      head_next_s = head_r + PW'(1);
    end else begin
      head_next_s = head_r;
    end
    if (push_s) begin
      tail_next_s = tail_r + PW'(1);
    end else begin
      tail_next_s = tail_r;
    end
    case ({push_s, pop_s})
      2'b10:   count_next_s = count_r + ONE_C;
      2'b01:   count_next_s = count_r - ONE_C;
      default: count_next_s = count_r;
    endcase
  end

  // Control state; Full/Empty are decoded from the next count so they stay registered.
  always_ff @(posedge Clock or negedge nReset) begin
    if (!nReset) begin
      head_r     <= '0;
      tail_r     <= '0;
      count_r    <= '0;
      empty_r    <= 1'b1;
      full_r     <= 1'b0;
      overflow_r <= 1'b0;
    end else begin
      head_r     <= head_next_s;
      tail_r     <= tail_next_s;
      count_r    <= count_next_s;
      empty_r    <= (count_next_s == '0);
      full_r     <= (count_next_s == DEPTH_C);
      overflow_r <= overflow_r | overflow_set_s;
    end
  end

  // Entry storage; contents are don't-care after reset so no reset is applied.
  always_ff @(posedge Clock) begin
    if (push_s) begin
      addr_mem_r[tail_r] <= MemAddr;
      data_mem_r[tail_r] <= WriteData;
    end
`ifdef DMEM_COALESCE_EN
    else if (coalesce_s) begin
      data_mem_r[tail_last_s] <= WriteData;
    end
`endif
  end

  // Walk oldest to youngest so the youngest matching entry wins; popping entries still count.
  always_comb begin
    fwd_hit_s  = 1'b0;
    fwd_data_s = '0;
    for (int i = 0; i < DEPTH; i++) begin
      fwd_data_s = ((CW'(i) < count_r) && (addr_mem_r[head_r + PW'(i)] == MemAddr))
                   ? data_mem_r[head_r + PW'(i)] : fwd_data_s;
      fwd_hit_s  = fwd_hit_s |
                   ((CW'(i) < count_r) && (addr_mem_r[head_r + PW'(i)] == MemAddr));
    end
  end

  assign MemData = (MemRead && fwd_hit_s) ? fwd_data_s : RamRData;

endmodule

// File: tb/tb_dmem_store_buffer.sv
// Directed self-checking bench for dmem_store_buffer; RAM writes are logged at each accepted handshake.
// Coalescing expectations are selected with DMEM_COALESCE_EN.
module tb_dmem_store_buffer;

  logic        Clock;
  logic        nReset;
  logic [15:0] MemAddr;
  logic        MemWrite;
  logic        MemRead;
  logic [31:0] WriteData;
  logic [31:0] MemData;
  logic        RamWReq;
  logic [15:0] RamWAddr;
  logic [31:0] RamWData;
  logic        RamWAck;
  logic [15:0] RamRAddr;
  logic [31:0] RamRData;
  logic        Full;
  logic        Empty;
  logic        Overflow;

  int compared;
  int mismatched;

  logic [15:0] wa_q [$];
  logic [31:0] wd_q [$];

  dmem_store_buffer #(.DEPTH(4), .AW(16), .DW(32)) dut (
    .Clock    (Clock),
    .nReset   (nReset),
    .MemAddr  (MemAddr),
    .MemWrite (MemWrite),
    .MemRead  (MemRead),
    .WriteData(WriteData),
    .MemData  (MemData),
    .RamWReq  (RamWReq),
    .RamWAddr (RamWAddr),
    .RamWData (RamWData),
    .RamWAck  (RamWAck),
    .RamRAddr (RamRAddr),
    .RamRData (RamRData),
    .Full     (Full),
    .Empty    (Empty),
    .Overflow (Overflow)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  // Record every write the RAM accepts.
  always @(posedge Clock) begin
    if (RamWReq && RamWAck) begin
      wa_q.push_back(RamWAddr);
      wd_q.push_back(RamWData);
    end
  end

  task automatic tick();
    @(posedge Clock);
    #2;
  endtask

  task automatic apply_reset();
    nReset = 1'b0;
    #3;
    nReset = 1'b1;
    #1;
  endtask

  task automatic test_reset();
    MemRead = 1'b1;
    MemAddr = 16'h0010;
    #1;
    compared++; if (Empty !== 1'b1) begin mismatched++; $display("FAIL reset_empty: got %b want 1", Empty); end
    compared++; if (Full !== 1'b0) begin mismatched++; $display("FAIL reset_full: got %b want 0", Full); end
    compared++; if (RamWReq !== 1'b0) begin mismatched++; $display("FAIL reset_wreq: got %b want 0", RamWReq); end
    compared++; if (Overflow !== 1'b0) begin mismatched++; $display("FAIL reset_ovf: got %b want 0", Overflow); end
    compared++; if (MemData !== 32'hDEADBEEF) begin mismatched++; $display("FAIL reset_memdata: got %h want deadbeef", MemData); end
    compared++; if (RamRAddr !== 16'h0010) begin mismatched++; $display("FAIL reset_raddr: got %h want 0010", RamRAddr); end
  endtask

  task automatic test_single_store();
    wa_q.delete(); wd_q.delete();
    MemRead = 1'b0; MemWrite = 1'b1; MemAddr = 16'h0004; WriteData = 32'h11111111; RamWAck = 1'b0;
    tick();
    MemWrite = 1'b0;
    #1;
    compared++; if (RamWReq !== 1'b1) begin mismatched++; $display("FAIL single_wreq: got %b want 1", RamWReq); end
    compared++; if (RamWAddr !== 16'h0004) begin mismatched++; $display("FAIL single_waddr: got %h want 0004", RamWAddr); end
    compared++; if (RamWData !== 32'h11111111) begin mismatched++; $display("FAIL single_wdata: got %h want 11111111", RamWData); end
    compared++; if (Empty !== 1'b0) begin mismatched++; $display("FAIL single_empty: got %b want 0", Empty); end
    tick();
    compared++; if (RamWData !== 32'h11111111) begin mismatched++; $display("FAIL single_hold: got %h want 11111111", RamWData); end
    RamWAck = 1'b1;
    tick();
    RamWAck = 1'b0;
    #1;
    compared++; if (Empty !== 1'b1) begin mismatched++; $display("FAIL single_drained: got %b want 1", Empty); end
    compared++; if (RamWReq !== 1'b0) begin mismatched++; $display("FAIL single_wreq_off: got %b want 0", RamWReq); end
    compared++; if (wd_q.size() !== 1) begin mismatched++; $display("FAIL single_wcount: got %0d want 1", wd_q.size()); end
  endtask

  task automatic test_forward_order();
    wa_q.delete(); wd_q.delete();
    MemWrite = 1'b1; MemAddr = 16'h0008; WriteData = 32'h0000000A;
    tick();
    WriteData = 32'h0000000B;
    tick();
    MemWrite = 1'b0; MemRead = 1'b1;
    #1;
    compared++; if (MemData !== 32'h0000000B) begin mismatched++; $display("FAIL fwd_youngest: got %h want 0000000b", MemData); end
    MemWrite = 1'b1; WriteData = 32'h0000000C;
    #1;
    compared++; if (MemData !== 32'h0000000B) begin mismatched++; $display("FAIL fwd_same_cycle: got %h want 0000000b", MemData); end
    MemWrite = 1'b0; MemRead = 1'b0;
    #1;
    compared++; if (MemData !== 32'hDEADBEEF) begin mismatched++; $display("FAIL fwd_noread: got %h want deadbeef", MemData); end
    RamWAck = 1'b1;
    tick();
    tick();
    RamWAck = 1'b0;
    #1;
    compared++; if (Empty !== 1'b1) begin mismatched++; $display("FAIL fwd_drained: got %b want 1", Empty); end
    compared++; if (wd_q.size() !== 2) begin mismatched++; $display("FAIL fwd_wcount: got %0d want 2", wd_q.size()); end
    compared++; if (wd_q[0] !== 32'h0000000A) begin mismatched++; $display("FAIL fwd_order0: got %h want 0000000a", wd_q[0]); end
    compared++; if (wd_q[1] !== 32'h0000000B) begin mismatched++; $display("FAIL fwd_order1: got %h want 0000000b", wd_q[1]); end
  endtask

  task automatic test_coalesce();
    wa_q.delete(); wd_q.delete();
    MemWrite = 1'b1; MemAddr = 16'h0020; WriteData = 32'h00000001; RamWAck = 1'b0;
    tick();
    WriteData = 32'h00000002;
    tick();
    MemWrite = 1'b0;
    #1;
    compared++; if (RamWData !== 32'h00000002) begin mismatched++; $display("FAIL coal_wdata: got %h want 00000002", RamWData); end
    compared++; if (RamWAddr !== 16'h0020) begin mismatched++; $display("FAIL coal_waddr: got %h want 0020", RamWAddr); end
    RamWAck = 1'b1;
    tick();
    RamWAck = 1'b0;
    #1;
    compared++; if (Empty !== 1'b1) begin mismatched++; $display("FAIL coal_one_entry: got %b want 1", Empty); end
    compared++; if (wd_q.size() !== 1) begin mismatched++; $display("FAIL coal_wcount: got %0d want 1", wd_q.size()); end
  endtask

  task automatic test_overflow();
    wa_q.delete(); wd_q.delete();
    RamWAck = 1'b0; MemRead = 1'b1;
    for (int i = 0; i < 4; i++) begin
      MemWrite = 1'b1; MemAddr = 16'h0100 + 16'(i * 4); WriteData = 32'(i + 1);
      tick();
    end
    MemWrite = 1'b0;
    #1;
    compared++; if (Full !== 1'b1) begin mismatched++; $display("FAIL ovf_full: got %b want 1", Full); end
    compared++; if (Overflow !== 1'b0) begin mismatched++; $display("FAIL ovf_pre: got %b want 0", Overflow); end
    MemWrite = 1'b1; MemAddr = 16'h0200; WriteData = 32'h00000055;
    tick();
    MemWrite = 1'b0;
    #1;
    compared++; if (Overflow !== 1'b1) begin mismatched++; $display("FAIL ovf_set: got %b want 1", Overflow); end
    compared++; if (MemData !== 32'hDEADBEEF) begin mismatched++; $display("FAIL ovf_dropped: got %h want deadbeef", MemData); end
    MemAddr = 16'h0108;
    #1;
    compared++; if (MemData !== 32'h00000003) begin mismatched++; $display("FAIL ovf_fwd: got %h want 00000003", MemData); end
    RamWAck = 1'b1;
    for (int i = 0; i < 4; i++) tick();
    RamWAck = 1'b0;
    #1;
    compared++; if (Empty !== 1'b1) begin mismatched++; $display("FAIL ovf_drained: got %b want 1", Empty); end
    compared++; if (Overflow !== 1'b1) begin mismatched++; $display("FAIL ovf_sticky: got %b want 1", Overflow); end
    compared++; if (wd_q.size() !== 4) begin mismatched++; $display("FAIL ovf_wcount: got %0d want 4", wd_q.size()); end
    compared++; if (wa_q[3] !== 16'h010C) begin mismatched++; $display("FAIL ovf_last_addr: got %h want 010c", wa_q[3]); end
  endtask

  task automatic test_full_push_pop();
    apply_reset();
    wa_q.delete(); wd_q.delete();
    RamWAck = 1'b0;
    for (int i = 0; i < 4; i++) begin
      MemWrite = 1'b1; MemAddr = 16'h0300 + 16'(i * 4); WriteData = 32'h30 + 32'(i);
      tick();
    end
    MemAddr = 16'h0340; WriteData = 32'h00000099; RamWAck = 1'b1;
    tick();
    MemWrite = 1'b0; RamWAck = 1'b0; MemRead = 1'b1;
    #1;
    compared++; if (Full !== 1'b1) begin mismatched++; $display("FAIL fpp_full: got %b want 1", Full); end
    compared++; if (Overflow !== 1'b0) begin mismatched++; $display("FAIL fpp_ovf: got %b want 0", Overflow); end
    compared++; if (RamWAddr !== 16'h0304) begin mismatched++; $display("FAIL fpp_head_addr: got %h want 0304", RamWAddr); end
    compared++; if (RamWData !== 32'h00000031) begin mismatched++; $display("FAIL fpp_head_data: got %h want 00000031", RamWData); end
    compared++; if (MemData !== 32'h00000099) begin mismatched++; $display("FAIL fpp_accepted: got %h want 00000099", MemData); end
    compared++; if (wa_q[0] !== 16'h0300) begin mismatched++; $display("FAIL fpp_written: got %h want 0300", wa_q[0]); end
  endtask

  task automatic test_async_reset();
    RamWAck = 1'b1;
    tick();
    RamWAck = 1'b0;
    #1;
    compared++; if (RamWReq !== 1'b1) begin mismatched++; $display("FAIL areset_pending: got %b want 1", RamWReq); end
    nReset = 1'b0;
    #1;
    compared++; if (RamWReq !== 1'b0) begin mismatched++; $display("FAIL areset_wreq_async: got %b want 0", RamWReq); end
    compared++; if (Empty !== 1'b1) begin mismatched++; $display("FAIL areset_empty: got %b want 1", Empty); end
    nReset = 1'b1;
    MemRead = 1'b1; MemAddr = 16'h0308; RamRData = 32'h12345678;
    #1;
    compared++; if (MemData !== 32'h12345678) begin mismatched++; $display("FAIL areset_load: got %h want 12345678", MemData); end
    tick();
    compared++; if (Empty !== 1'b1) begin mismatched++; $display("FAIL areset_stays_empty: got %b want 1", Empty); end
    compared++; if (RamWReq !== 1'b0) begin mismatched++; $display("FAIL areset_no_req: got %b want 0", RamWReq); end
  endtask

  initial begin
    compared = 0;
    mismatched = 0;
    nReset = 1'b0;
    MemAddr = 16'h0000;
    MemWrite = 1'b0;
    MemRead = 1'b0;
    WriteData = 32'h00000000;
    RamWAck = 1'b0;
    RamRData = 32'hDEADBEEF;
    #12;
    nReset = 1'b1;
    test_reset();
    test_single_store();
`ifdef DMEM_COALESCE_EN
    test_coalesce();
`else
    test_forward_order();
`endif
    test_overflow();
    test_full_push_pop();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
